// File: rtl/sequence_generator_010_1001.sv
// Serial pattern transmitter: emits 010 or 1001 MSB-first, count times, with idle gaps.
// Optional build macro SEQGEN_ABORT_EN adds an abort input that cancels a transfer.
module sequence_generator_010_1001 #(
    parameter int   CNT_W    = 8,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sel,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
`ifdef SEQGEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             pattern_end,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a request taken on a rising edge only while the FSM is
    // in IDLE (busy=0, not the FIN cycle); there is no back-pressure on x/valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic               sel_q, sel_n;
    logic [CNT_W-1:0]   rem, rem_n;
    logic [GAP_W-1:0]   gap_len, gap_len_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [1:0]         bit_idx, bit_n;
    logic [1:0]         last_idx;
    logic               x_n, valid_n, busy_n, pattern_end_n, done_n;

    assign last_idx  = sel_q ? 2'd3 : 2'd2;
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        rem_n     = rem;
        gap_len_n = gap_len;
        gap_cnt_n = gap_cnt;
        bit_n     = bit_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    sel_n     = sel;
                    rem_n     = count;
                    gap_len_n = gap;
                    bit_n     = 2'd0;
                    gap_cnt_n = '0;
                    state_n   = (count == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (bit_idx != last_idx) begin
                    bit_n = 2'(bit_idx + 2'd1);
                end else begin
                    rem_n = rem - CNT_W'(1);
                    bit_n = 2'd0;
                    if (rem == CNT_W'(1)) begin
                        state_n = FIN;
                    end else if (gap_len != '0) begin
                        state_n   = GAP;
                        gap_cnt_n = gap_len;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_n   = SEND;
                    gap_cnt_n = '0;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef SEQGEN_ABORT_EN
        // Abort overrides every other transition while a transfer is in flight.
        if (abort && (state == SEND || state == GAP)) begin
            state_n   = IDLE;
            bit_n     = 2'd0;
            gap_cnt_n = '0;
            rem_n     = '0;
        end
`endif
    end

    // Outputs are registered views of the next state, so they line up with it.
    always_comb begin
        x_n           = IDLE_LVL;
        valid_n       = 1'b0;
        busy_n        = (state_n == SEND) || (state_n == GAP);
        pattern_end_n = 1'b0;
        done_n        = (state_n == FIN);
        if (state_n == SEND) begin
            valid_n       = 1'b1;
            x_n           = sel_n ? ((bit_n == 2'd0) || (bit_n == 2'd3)) : (bit_n == 2'd1);
            pattern_end_n = (bit_n == (sel_n ? 2'd3 : 2'd2));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel_q       <= 1'b0;
            rem         <= '0;
            gap_len     <= '0;
            gap_cnt     <= '0;
            bit_idx     <= 2'd0;
            x           <= IDLE_LVL;
            valid       <= 1'b0;
            busy        <= 1'b0;
            pattern_end <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            sel_q       <= sel_n;
            rem         <= rem_n;
            gap_len     <= gap_len_n;
            gap_cnt     <= gap_cnt_n;
            bit_idx     <= bit_n;
            x           <= x_n;
            valid       <= valid_n;
            busy        <= busy_n;
            pattern_end <= pattern_end_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_sequence_generator_010_1001.sv
// Bench for sequence_generator_010_1001: per-cycle expected output words
// {x,valid,busy,pattern_end,done} are queued at start and compared each cycle.
module tb_sequence_generator_010_1001;

    localparam logic IDLE_LVL = 1'b1;
    localparam logic [4:0] IDLE_W = {IDLE_LVL, 4'b0000};

    logic       clk;
    logic       reset;
    logic       start;
    logic       sel;
    logic [7:0] count;
    logic [3:0] gap;
    logic       abort;
    logic       x, valid, busy, pattern_end, done;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic        sel;
        logic [7:0]  count;
        logic [3:0]  gap;
        int          len;
        logic [15:0] x_b;
        logic [15:0] v_b;
        logic [15:0] b_b;
        logic [15:0] pe_b;
        logic [15:0] d_b;
    } vec_t;

    vec_t vecs[6];

    sequence_generator_010_1001 #(.CNT_W(8), .GAP_W(4), .IDLE_LVL(IDLE_LVL)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .sel(sel),
        .count(count),
        .gap(gap),
`ifdef SEQGEN_ABORT_EN
        .abort(abort),
`endif
        .x(x),
        .valid(valid),
        .busy(busy),
        .pattern_end(pattern_end),
        .done(done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard: one expected word per cycle after each active edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("stream", {3'b000, x, valid, busy, pattern_end, done}, {3'b000, e});
        end
    end

    // reference stream for one transfer, truncated to max_w words
    task automatic push_model(input logic s, input int cnt, input int g, input int max_w);
        int n;
        int len;
        logic [3:0] pat;
        n   = 0;
        len = s ? 4 : 3;
        pat = s ? 4'b1001 : 4'b0010;
        for (int r = 0; r < cnt; r++) begin
            for (int b = 0; b < len; b++) begin
                if (n < max_w) exp_q.push_back({pat[len-1-b], 1'b1, 1'b1, (b == len - 1), 1'b0});
                n++;
            end
            if (r < cnt - 1) begin
                for (int k = 0; k < g; k++) begin
                    if (n < max_w) exp_q.push_back({IDLE_LVL, 1'b0, 1'b1, 2'b00});
                    n++;
                end
            end
        end
        if (n < max_w) exp_q.push_back({IDLE_LVL, 4'b0001});
    endtask

    // driver: call at a negedge with expectations already queued
    task automatic drive_start(input logic s, input logic [7:0] c, input logic [3:0] g);
        sel   = s;
        count = c;
        gap   = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d_left exp=0_left", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {3'b000, x, valid, busy, pattern_end, done}, {3'b000, IDLE_W});
        check({name, "_state"}, {6'd0, state_dbg}, 8'd0);
    endtask

    initial begin
        // table: MSB-first over len cycles, cycle 1 follows the sampling edge
        vecs[0] = '{sel:1'b0, count:8'd1, gap:4'd0, len:4,
                    x_b:16'b0101, v_b:16'b1110, b_b:16'b1110, pe_b:16'b0010, d_b:16'b0001};
        vecs[1] = '{sel:1'b1, count:8'd2, gap:4'd2, len:11,
                    x_b:16'b10011110011, v_b:16'b11110011110, b_b:16'b11111111110,
                    pe_b:16'b00010000010, d_b:16'b00000000001};
        vecs[2] = '{sel:1'b0, count:8'd3, gap:4'd0, len:10,
                    x_b:16'b0100100101, v_b:16'b1111111110, b_b:16'b1111111110,
                    pe_b:16'b0010010010, d_b:16'b0000000001};
        vecs[3] = '{sel:1'b1, count:8'd0, gap:4'd3, len:1,
                    x_b:16'b1, v_b:16'b0, b_b:16'b0, pe_b:16'b0, d_b:16'b1};
        vecs[4] = '{sel:1'b1, count:8'd1, gap:4'd5, len:5,
                    x_b:16'b10011, v_b:16'b11110, b_b:16'b11110, pe_b:16'b00010, d_b:16'b00001};
        vecs[5] = '{sel:1'b0, count:8'd2, gap:4'd1, len:8,
                    x_b:16'b01010101, v_b:16'b11101110, b_b:16'b11111110,
                    pe_b:16'b00100010, d_b:16'b00000001};

        reset = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        count = '0;
        gap   = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", {3'b000, x, valid, busy, pattern_end, done}, {3'b000, IDLE_W});
        check("reset_state", {6'd0, state_dbg}, 8'd0);
        reset = 1'b1;
        check_idle("post_reset");

        foreach (vecs[i]) begin
            for (int k = 1; k <= vecs[i].len; k++) begin
                int b;
                b = vecs[i].len - k;
                exp_q.push_back({vecs[i].x_b[b], vecs[i].v_b[b], vecs[i].b_b[b],
                                 vecs[i].pe_b[b], vecs[i].d_b[b]});
            end
            drive_start(vecs[i].sel, vecs[i].count, vecs[i].gap);
            wait_drain(100);
            check_idle("vec_idle");
        end

        for (int t = 0; t < 8; t++) begin
            logic       s;
            logic [7:0] c;
            logic [3:0] g;
            s = 1'($urandom_range(0, 1));
            c = 8'($urandom_range(0, 5));
            g = 4'($urandom_range(0, 3));
            push_model(s, int'(c), int'(g), 1000);
            drive_start(s, c, g);
            wait_drain(200);
            check_idle("rand_idle");
        end

        // maximum repetition count must not wrap
        push_model(1'b0, 255, 0, 1000);
        drive_start(1'b0, 8'd255, 4'd0);
        wait_drain(2000);
        check_idle("max_count_idle");

        // start held high: ignored through FIN, taken in the following IDLE cycle
        push_model(1'b0, 2, 0, 1000);
        exp_q.push_back(IDLE_W);
        push_model(1'b1, 1, 3, 1000);
        sel   = 1'b0;
        count = 8'd2;
        gap   = 4'd0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        sel   = 1'b1;
        count = 8'd1;
        gap   = 4'd3;
        repeat (7) @(negedge clk);
        start = 1'b0;
        wait_drain(100);
        check_idle("hold_idle");

        // reset in cycle 2 of a transfer
        push_model(1'b1, 4, 0, 2);
        drive_start(1'b1, 8'd4, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset", {3'b000, x, valid, busy, pattern_end, done}, {3'b000, IDLE_W});
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("in_reset", {3'b000, x, valid, busy, pattern_end, done}, {3'b000, IDLE_W});
        end
        reset = 1'b1;
        @(negedge clk);
        push_model(1'b1, 1, 0, 1000);
        drive_start(1'b1, 8'd1, 4'd0);
        wait_drain(100);
        check_idle("after_reset_idle");

`ifdef SEQGEN_ABORT_EN
        // abort during the gap cycle (cycle 5) of sel=1, count=3, gap=1
        push_model(1'b1, 3, 1, 5);
        exp_q.push_back(IDLE_W);
        exp_q.push_back(IDLE_W);
        drive_start(1'b1, 8'd3, 4'd1);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain(100);
        check_idle("abort_idle");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
